// File: rtl/ir_nec_decoder.sv
// NEC infrared remote-control frame decoder.
// Measures burst/space durations in ticks and validates address/command frames.
module ir_nec_decoder #(
    parameter int TICK_CYCLES = 1250,
    parameter int LEAD_MIN    = 160,
    parameter int LEAD_MAX    = 200,
    parameter int HDR_MIN     = 80,
    parameter int HDR_MAX     = 100,
    parameter int RPT_MIN     = 36,
    parameter int RPT_MAX     = 54,
    parameter int BIT_MIN     = 8,
    parameter int BIT_MAX     = 14,
    parameter int ONE_MIN     = 28,
    parameter int ONE_MAX     = 40
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       In_Data,
    output logic [7:0] Address,
    output logic [7:0] Command,
    output logic       Valid,
    output logic       Repeat,
    output logic       Error
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_BURST,
        S_LEAD_SPACE,
        S_BIT_BURST,
        S_BIT_SPACE,
        S_STOP_BURST,
        S_RPT_STOP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_s1, r_s2, r_prev;
    logic [PW-1:0]   r_pre;
    logic [7:0]      r_dur;
    logic [31:0]     r_shift;
    logic [4:0]      r_cnt;
    logic            r_have;
    logic            w_rise, w_fall, w_edge, w_tick;
    logic            w_valid, w_repeat, w_error;
    logic            w_shift, w_bit, w_clr_cnt, w_load, w_cmp_ok;

    function automatic logic in_win(input logic [7:0] d, input int lo, input int hi);
        int dv;
        dv = int'({24'd0, d});
        return (dv >= lo) && (dv <= hi);
    endfunction

    assign w_rise   = r_s2 & ~r_prev;
    assign w_fall   = ~r_s2 & r_prev;
    assign w_edge   = r_s2 ^ r_prev;
    assign w_tick   = (r_pre == TICK_LAST);
    assign w_cmp_ok = (r_shift[15:8] == ~r_shift[7:0]) &&
                      (r_shift[31:24] == ~r_shift[23:16]);

    // Two-flop synchronizer plus delayed copy for edge detection
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= In_Data;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    // Free-running tick prescaler and saturating duration counter
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_pre <= '0;
            r_dur <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_edge)
                r_dur <= '0;
            else if (w_tick && r_dur != 8'hFF)
                r_dur <= r_dur + 8'd1;
        end
    end

    // FSM state register
    always_ff @(posedge Clock) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state and strobe decode; each duration judged on the edge ending it
    always_comb begin
        w_next    = r_state;
        w_valid   = 1'b0;
        w_repeat  = 1'b0;
        w_error   = 1'b0;
        w_shift   = 1'b0;
        w_bit     = 1'b0;
        w_clr_cnt = 1'b0;
        w_load    = 1'b0;
        if (r_state != S_IDLE && r_dur == 8'hFF) begin
            w_error = 1'b1;
            w_next  = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_rise) w_next = S_LEAD_BURST;
                end
                S_LEAD_BURST: begin
                    if (w_fall) begin
                        if (in_win(r_dur, LEAD_MIN, LEAD_MAX)) begin
                            w_next = S_LEAD_SPACE;
                        end else begin
                            w_error = 1'b1;
                            w_next  = S_IDLE;
                        end
                    end
                end
                S_LEAD_SPACE: begin
                    if (w_rise) begin
                        if (in_win(r_dur, HDR_MIN, HDR_MAX)) begin
                            w_next    = S_BIT_BURST;
                            w_clr_cnt = 1'b1;
                        end else if (in_win(r_dur, RPT_MIN, RPT_MAX)) begin
                            w_next = S_RPT_STOP;
                        end else begin
                            w_error = 1'b1;
                            w_next  = S_IDLE;
                        end
                    end
                end
                S_BIT_BURST: begin
                    if (w_fall) begin
                        if (in_win(r_dur, BIT_MIN, BIT_MAX)) begin
                            w_next = S_BIT_SPACE;
                        end else begin
                            w_error = 1'b1;
                            w_next  = S_IDLE;
                        end
                    end
                end
                S_BIT_SPACE: begin
                    if (w_rise) begin
                        if (in_win(r_dur, BIT_MIN, BIT_MAX) ||
                            in_win(r_dur, ONE_MIN, ONE_MAX)) begin
                            w_shift = 1'b1;
                            w_bit   = in_win(r_dur, ONE_MIN, ONE_MAX);
                            w_next  = (r_cnt == 5'd31) ? S_STOP_BURST : S_BIT_BURST;
                        end else begin
                            w_error = 1'b1;
                            w_next  = S_IDLE;
                        end
                    end
                end
                S_STOP_BURST: begin
                    if (w_fall) begin
                        w_next = S_IDLE;
                        if (in_win(r_dur, BIT_MIN, BIT_MAX) && w_cmp_ok) begin
                            w_valid = 1'b1;
                            w_load  = 1'b1;
                        end else begin
                            w_error = 1'b1;
                        end
                    end
                end
                S_RPT_STOP: begin
                    if (w_fall) begin
                        w_next = S_IDLE;
                        if (in_win(r_dur, BIT_MIN, BIT_MAX) && r_have)
                            w_repeat = 1'b1;
                        else
                            w_error = 1'b1;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Frame datapath, latched outputs and registered strobes
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_have  <= 1'b0;
            Address <= '0;
            Command <= '0;
            Valid   <= 1'b0;
            Repeat  <= 1'b0;
            Error   <= 1'b0;
        end else begin
            Valid  <= w_valid;
            Repeat <= w_repeat;
            Error  <= w_error;
            if (w_clr_cnt) r_cnt <= '0;
            if (w_shift) begin
                r_shift <= {w_bit, r_shift[31:1]};
                r_cnt   <= r_cnt + 5'd1;
            end
            if (w_load) begin
                Address <= r_shift[7:0];
                Command <= r_shift[23:16];
                r_have  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Testbench for ir_nec_decoder.
// Pulse-train stimulus judged by a frame-level reference model.
module tb_ir_nec_decoder;

    localparam int TC = 4;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       In_Data;
    logic [7:0] Address;
    logic [7:0] Command;
    logic       Valid;
    logic       Repeat;
    logic       Error;

    always #5 Clock = ~Clock;

    ir_nec_decoder #(.TICK_CYCLES(TC)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .In_Data (In_Data),
        .Address (Address),
        .Command (Command),
        .Valid   (Valid),
        .Repeat  (Repeat),
        .Error   (Error)
    );

    int cyc = 0;
    int vecs = 0;
    int errs = 0;
    int n_v = 0, n_r = 0, n_e = 0;
    int v_cyc = 0, e_cyc = 0, fall_cyc = 0;
    logic [7:0] m_addr = 8'd0;
    logic [7:0] m_cmd = 8'd0;
    bit m_have = 1'b0;
    int seq[$];

    // Cycle counter
    always @(posedge Clock) cyc <= cyc + 1;

    // Strobe monitor, sampled on the inactive edge
    always @(negedge Clock) begin
        if (Valid) begin n_v++; v_cyc = cyc; end
        if (Repeat) n_r++;
        if (Error) begin n_e++; e_cyc = cyc; end
        if (Valid || Repeat || Error) begin
            vecs++;
            assert ((int'(Valid) + int'(Repeat) + int'(Error)) <= 1) else begin
                errs++;
                $error("FAIL onehot: observed V%0d R%0d E%0d, expected at most one",
                       Valid, Repeat, Error);
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit inw(input int d, input int lo, input int hi);
        return (d >= lo) && (d <= hi);
    endfunction

    function automatic int get(input int i);
        return (i < seq.size()) ? seq[i] : 0;
    endfunction

    function automatic int pick(input int lo, input int hi, input int nom, input bit rnd);
        return rnd ? int'($urandom_range(hi - 1, lo + 2)) : nom;
    endfunction

    // Expected outcome of the pulse train: 0 none, 1 valid, 2 repeat, 3 error
    function automatic int model();
        logic [31:0] w;
        int s;
        w = '0;
        if (!inw(get(0), 160, 200)) return 3;
        if (inw(get(1), 80, 100)) begin
            for (int b = 0; b < 32; b++) begin
                if (!inw(get(2 + 2 * b), 8, 14)) return 3;
                s = get(3 + 2 * b);
                if (inw(s, 8, 14))       w[b] = 1'b0;
                else if (inw(s, 28, 40)) w[b] = 1'b1;
                else                     return 3;
            end
            if (!inw(get(66), 8, 14)) return 3;
            if (w[15:8] == ~w[7:0] && w[31:24] == ~w[23:16]) begin
                m_addr = w[7:0];
                m_cmd  = w[23:16];
                m_have = 1'b1;
                return 1;
            end
            return 3;
        end
        if (inw(get(1), 36, 54)) begin
            if (inw(get(2), 8, 14) && m_have) return 2;
            return 3;
        end
        return 3;
    endfunction

    task automatic idle(input int ticks);
        repeat (ticks * TC) @(negedge Clock);
    endtask

    task automatic play(input int n);
        for (int i = 0; i < n; i++) begin
            In_Data = (i % 2 == 0);
            if (i % 2 == 1) fall_cyc = cyc;
            repeat (seq[i] * TC) @(negedge Clock);
        end
        if (n % 2 == 1) begin
            In_Data  = 1'b0;
            fall_cyc = cyc;
        end
    endtask

    task automatic mk_frame(input logic [7:0] a, input logic [7:0] b1,
                            input logic [7:0] c, input logic [7:0] b3,
                            input bit rnd);
        logic [31:0] w;
        w = {b3, c, b1, a};
        seq.delete();
        seq.push_back(pick(160, 200, 180, rnd));
        seq.push_back(pick(80, 100, 90, rnd));
        for (int i = 0; i < 32; i++) begin
            seq.push_back(pick(8, 14, 11, rnd));
            seq.push_back(w[i] ? pick(28, 40, 34, rnd) : pick(8, 14, 11, rnd));
        end
        seq.push_back(pick(8, 14, 11, rnd));
    endtask

    task automatic mk_rpt(input bit rnd);
        seq.delete();
        seq.push_back(pick(160, 200, 180, rnd));
        seq.push_back(pick(36, 54, 45, rnd));
        seq.push_back(pick(8, 14, 11, rnd));
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        Reset  = 1'b0;
        m_addr = 8'd0;
        m_cmd  = 8'd0;
        m_have = 1'b0;
        idle(5);
    endtask

    task automatic txn(input string tag);
        int code, v0, r0, e0;
        code = model();
        v0 = n_v; r0 = n_r; e0 = n_e;
        play(seq.size());
        idle(10);
        chk({tag, "_valid"}, n_v - v0, (code == 1) ? 1 : 0);
        chk({tag, "_repeat"}, n_r - r0, (code == 2) ? 1 : 0);
        chk({tag, "_error"}, n_e - e0, (code == 3) ? 1 : 0);
        chk({tag, "_addr"}, Address, m_addr);
        chk({tag, "_cmd"}, Command, m_cmd);
    endtask

    initial begin
        int v0, r0, e0, dt, kind;
        logic [7:0] a, c, b3;
        In_Data = 1'b0;
        Reset   = 1'b1;
        repeat (4) @(negedge Clock);
        chk("rst_addr", Address, 0);
        chk("rst_cmd", Command, 0);
        chk("rst_strobes", int'(Valid) + int'(Repeat) + int'(Error), 0);
        Reset = 1'b0;
        idle(5);

        mk_frame(8'h04, 8'hFB, 8'h08, 8'hF7, 1'b0);
        txn("frame04");
        chk("latency", v_cyc - fall_cyc, 3);

        mk_rpt(1'b0);
        txn("repeat");

        do_reset();
        mk_rpt(1'b0);
        txn("rpt_nohave");

        mk_frame(8'h55, 8'hAA, 8'h3C, 8'hC3, 1'b0);
        txn("frame55");
        mk_frame(8'h10, 8'hEF, 8'h08, 8'hF6, 1'b0);
        txn("corrupt");

        seq.delete();
        seq.push_back(150);
        txn("short_lead");
        mk_frame(8'h21, 8'hDE, 8'h5A, 8'hA5, 1'b0);
        txn("frame21");

        mk_frame(8'hA5, 8'h5A, 8'h3C, 8'hC3, 1'b0);
        v0 = n_v; r0 = n_r; e0 = n_e;
        play(27);
        idle(5);
        do_reset();
        idle(20);
        chk("midrst_strobes", (n_v - v0) + (n_r - r0) + (n_e - e0), 0);
        chk("midrst_addr", Address, 0);
        chk("midrst_cmd", Command, 0);
        txn("after_rst");

        mk_frame(8'h3C, 8'hC3, 8'h11, 8'hEE, 1'b0);
        seq = seq[0:12];
        seq.push_back(300);
        txn("timeout");
        dt = e_cyc - fall_cyc;
        chk("timeout_time", (dt >= 1016 && dt <= 1032) ? 1 : 0, 1);
        mk_frame(8'h77, 8'h88, 8'h99, 8'h66, 1'b0);
        txn("after_tmo");

        for (int k = 0; k < 4; k++) begin
            kind = int'($urandom_range(2, 0));
            a = 8'($urandom);
            c = 8'($urandom);
            if (kind == 0) begin
                mk_frame(a, ~a, c, ~c, 1'b1);
            end else if (kind == 1) begin
                mk_rpt(1'b1);
            end else begin
                b3 = ~c ^ 8'(1 << $urandom_range(7, 0));
                mk_frame(a, ~a, c, b3, 1'b1);
            end
            txn("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
